// File: rtl/vec_sram_ctrl.sv
// Vector-to-scalar SRAM access sequencer: splits one 128-bit vector load/store
// into LANES single-word accesses on a single-port SRAM and gathers load data.
module vec_sram_ctrl #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 30,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AWIDTH-1:0]       req_addr,
  input  logic [LANES-1:0]        req_mask,
  input  logic [WIDTH*LANES-1:0]  req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_we,
  output logic [WIDTH*LANES-1:0]  rsp_rdata,
  output logic                    sram_cs,
  output logic                    sram_rw,
  output logic [AWIDTH-1:0]       sram_addr,
  output logic [WIDTH-1:0]        sram_din,
  input  logic [WIDTH-1:0]        sram_dout
);

  localparam int LG = $clog2(LANES);
  localparam int VW = WIDTH * LANES;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [LG-1:0]     beat_q, beat_d;
  logic              we_q, we_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [VW-1:0]     wdata_q, wdata_d;
  logic [VW-1:0]     rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic              rw_q, rw_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  din_q, din_d;

  // Lanes are big-endian: lane 0 (lowest address) sits in the MSBs.
  function automatic logic [WIDTH-1:0] lane_of(input logic [VW-1:0] v,
                                               input logic [LG-1:0] i);
    return v[WIDTH*(LANES-1-int'(i)) +: WIDTH];
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_we    = we_q;
  assign rsp_rdata = rdata_q;
  assign sram_cs   = cs_q;
  assign sram_rw   = rw_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    we_d    = we_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ACCESS;
          beat_d  = '0;
          we_d    = req_we;
          mask_d  = req_mask;
          wdata_d = req_wdata;
          rdata_d = '0;
          // Beat 0 goes out on the acceptance edge; base is vector-aligned.
          cs_d    = req_we ? req_mask[0] : 1'b1;
          rw_d    = !req_we;
          addr_d  = req_addr & ~AWIDTH'(LANES - 1);
          din_d   = lane_of(req_wdata, '0);
        end
      end

      ACCESS: begin
        if (!we_q) begin
          rdata_d[WIDTH*(LANES-1-int'(beat_q)) +: WIDTH] = sram_dout;
        end
        if (beat_q == LG'(LANES - 1)) begin
          state_d = RESP;
          cs_d    = 1'b0;
          rw_d    = 1'b1;
        end else begin
          // Aligned base means the increment never carries past the vector.
          beat_d = beat_q + LG'(1);
          cs_d   = we_q ? mask_q[beat_d] : 1'b1;
          addr_d = addr_q + AWIDTH'(1);
          din_d  = lane_of(wdata_q, beat_d);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: tb/tb_vec_sram_ctrl.sv
// Scoreboard bench for vec_sram_ctrl: directed scenarios plus random traffic
// against an array-based memory model, with an SRAM model on the scalar port.
module tb_vec_sram_ctrl;

  localparam int WIDTH  = 32;
  localparam int AWIDTH = 30;
  localparam int LANES  = 4;
  localparam int VW     = WIDTH * LANES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AWIDTH-1:0] req_addr = '0;
  logic [LANES-1:0]  req_mask = '0;
  logic [VW-1:0]     req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_we;
  logic [VW-1:0]     rsp_rdata;
  logic              sram_cs;
  logic              sram_rw;
  logic [AWIDTH-1:0] sram_addr;
  logic [WIDTH-1:0]  sram_din;
  logic [WIDTH-1:0]  sram_dout;

  always #5 clk = ~clk;

  vec_sram_ctrl #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Single-port SRAM with combinational read; only the low 256 words are modelled.
  logic [WIDTH-1:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
  always @(posedge clk) if (sram_cs && !sram_rw) mem[sram_addr[7:0]] <= sram_din;
  assign sram_dout = mem[sram_addr[7:0]];

  typedef struct packed {logic we; logic [VW-1:0] rdata;} exp_t;
  typedef struct packed {logic rw; logic [AWIDTH-1:0] addr; logic [WIDTH-1:0] din;} bus_t;

  exp_t        exp_q[$];
  bus_t        bus_log[$];
  int          acc_log[$];
  logic [31:0] ref_mem [256];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_accept = 0;
  bit          prev_valid = 1'b0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [VW-1:0] v, input int i);
    return v[VW-1-WIDTH*i -: WIDTH];
  endfunction

  function automatic logic [VW-1:0] pack4(input logic [31:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic wait_accept();
    bit rdy;
    int n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 40) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    check("req_accepted", rdy, 1'b1);
    last_accept = cyc;
    acc_log.push_back(cyc);
    req_valid = 1'b0;
  endtask

  task automatic drive_req(input bit we, input logic [AWIDTH-1:0] addr,
                           input logic [LANES-1:0] mask, input logic [VW-1:0] wdata);
    req_we    = we;
    req_addr  = addr;
    req_mask  = mask;
    req_wdata = wdata;
    req_valid = 1'b1;
    wait_accept();
  endtask

  // Reference model: a vector op touches the 4 words of the aligned block.
  task automatic issue(input bit we, input logic [AWIDTH-1:0] addr,
                       input logic [LANES-1:0] mask, input logic [VW-1:0] wdata);
    exp_t e;
    int   b;
    b       = int'(addr[7:0]) & ~(LANES - 1);
    e.we    = we;
    e.rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (we) begin
        if (mask[i]) ref_mem[b+i] = lane(wdata, i);
      end else begin
        e.rdata[VW-1-WIDTH*i -: WIDTH] = ref_mem[b+i];
      end
    end
    exp_q.push_back(e);
    drive_req(we, addr, mask, wdata);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready && !rsp_valid) && n < 60);
    check("idle_reached", req_ready && !rsp_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: latency on the rising edge of rsp_valid, data on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rsp_valid && !prev_valid) check("rsp_latency", (cyc + 1) - last_accept, LANES + 1);
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_we", rsp_we, mon_e.we);
          check("rsp_rdata", rsp_rdata, mon_e.rdata);
        end
      end
    end
    prev_valid = rsp_valid;
  end

  // SRAM bus monitor: log every selected access.
  initial forever begin
    @(negedge clk);
    if (sram_cs === 1'b1) bus_log.push_back({sram_rw, sram_addr, sram_din});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] held;
    logic [VW-1:0] wd;
    int            n;
    bus_t          be;

    for (int k = 0; k < 256; k++) ref_mem[k] = 32'hC0DE_0000 | 32'(k);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_we", rsp_we, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_sram_cs", sram_cs, 1'b0);
    check("rst_sram_rw", sram_rw, 1'b1);
    check("rst_sram_addr", sram_addr, '0);
    check("rst_sram_din", sram_din, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // Full store then load of the same vector
    bus_log.delete();
    issue(1'b1, 30'h10, 4'b1111, 128'h11111111_22222222_33333333_44444444);
    wait_idle();
    check("store_beats", bus_log.size(), LANES);
    for (int i = 0; i < LANES && i < bus_log.size(); i++) begin
      be = bus_log[i];
      check("store_rw", be.rw, 1'b0);
      check("store_addr", be.addr, 30'h10 + 30'(i));
      check("store_din", be.din, 32'h11111111 * (i + 1));
    end
    issue(1'b0, 30'h10, 4'b0000, '0);
    wait_idle();

    // Misaligned load is aligned down
    bus_log.delete();
    issue(1'b0, 30'h13, 4'b0000, '0);
    wait_idle();
    check("misaligned_beats", bus_log.size(), LANES);
    for (int i = 0; i < LANES && i < bus_log.size(); i++) begin
      be = bus_log[i];
      check("misaligned_rw", be.rw, 1'b1);
      check("misaligned_addr", be.addr, 30'h10 + 30'(i));
    end

    // Partial store over a preloaded block: lanes 1 and 3 enabled
    issue(1'b1, 30'h20, 4'b1111, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    wait_idle();
    bus_log.delete();
    issue(1'b1, 30'h20, 4'b1010, pack4(32'hFF, 32'hFF, 32'hFF, 32'hFF));
    wait_idle();
    check("partial_beats", bus_log.size(), 2);
    if (bus_log.size() == 2) begin
      check("partial_addr0", bus_log[0].addr, 30'h21);
      check("partial_addr1", bus_log[1].addr, 30'h23);
      check("partial_din", bus_log[0].din, 32'hFF);
    end
    issue(1'b0, 30'h20, 4'b0000, '0);
    wait_idle();
    check("partial_model", pack4(ref_mem[32], ref_mem[33], ref_mem[34], ref_mem[35]),
          pack4(32'hA0, 32'hFF, 32'hA2, 32'hFF));

    // Store with empty mask: no selects, still a response
    bus_log.delete();
    issue(1'b1, 30'h28, 4'b0000, {4{32'hBAD0BAD0}});
    wait_idle();
    check("mask0_no_cs", bus_log.size(), 0);

    // Backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 30'h44, 4'b0000, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("bp_rsp_seen", rsp_valid, 1'b1);
    held = rsp_rdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_rdata", rsp_rdata, held);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_sram_cs", sram_cs, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", req_ready, 1'b1);
    check("bp_release_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;

    // Reset during a full store: beats 0-1 land, then the transfer is aborted
    wd = pack4(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003);
    drive_req(1'b1, 30'h30, 4'b1111, wd);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_sram_cs", sram_cs, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_sram_rw", sram_rw, 1'b1);
    check("abort_sram_addr", sram_addr, '0);
    check("abort_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[48] = lane(wd, 0);
    ref_mem[49] = lane(wd, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    issue(1'b0, 30'h30, 4'b0000, '0);
    wait_idle();

    // Back-to-back loads with req_valid kept high
    acc_log.delete();
    issue(1'b0, 30'h10, 4'b0000, '0);
    issue(1'b0, 30'h20, 4'b0000, '0);
    issue(1'b0, 30'h30, 4'b0000, '0);
    wait_idle();
    check("b2b_gap01", acc_log[1] - acc_log[0], LANES + 2);
    check("b2b_gap12", acc_log[2] - acc_log[1], LANES + 2);

    // Random traffic with random response stalls
    for (int t = 0; t < 60; t++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      issue(1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)),
            4'($urandom_range(0, 15)), wd);
      if ($urandom_range(0, 1) == 1) begin
        rsp_ready = 1'b0;
        repeat ($urandom_range(1, 9)) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    end
    wait_idle();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
